// File: rtl/encoder_speed_filter_if.sv
// Valid/ready result channel carrying the averaged speed from the filter to the packetizer.
// The filter drives it through the master modport; the consumer uses the slave modport.
interface encoder_speed_filter_if #(
  parameter int unsigned COUNT_WIDTH = 16
);
  logic [COUNT_WIDTH-1:0] o_Speed;
  logic                   o_Speed_Valid;
  logic                   i_Speed_Ready;

  modport master (
    output o_Speed,
    output o_Speed_Valid,
    input  i_Speed_Ready
  );

  modport slave (
    input  o_Speed,
    input  o_Speed_Valid,
    output i_Speed_Ready
  );
endinterface

// File: rtl/encoder_speed_filter.sv
// Moving-average filter over the last 2^AVG_LOG2 encoder pulse counts, with a valid/ready result.
// Stall detection is built only when ENC_FILTER_STALL_DETECT_EN is defined.
module encoder_speed_filter #(
  parameter int unsigned COUNT_WIDTH   = 16,
  parameter int unsigned AVG_LOG2      = 3,
  parameter int unsigned STALL_WINDOWS = 4
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic [COUNT_WIDTH-1:0] i_Pulse_Count,
  input  logic                   i_Data_Ready,
  encoder_speed_filter_if.master speed_if,
  output logic                   o_Primed,
  output logic                   o_Overrun,
  output logic                   o_Stalled
);

  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = COUNT_WIDTH + AVG_LOG2;
  localparam int unsigned FillW = AVG_LOG2 + 1;

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  logic [COUNT_WIDTH-1:0] mem_q [Depth];
  logic [AVG_LOG2-1:0]    wr_ptr_q, wr_ptr_d;
  logic [SumW-1:0]        sum_q, sum_d;
  logic [FillW-1:0]       fill_q, fill_d;
  logic                   pend_q;
  logic                   primed_q, primed_d;
  logic [COUNT_WIDTH-1:0] speed_q, speed_d;
  logic [0:0]             state_q, state_d;
  logic                   overrun_q, overrun_d;
  logic [COUNT_WIDTH-1:0] oldest;
  logic                   accept;

  // Stage 1: replace the oldest entry and adjust the running sum by the difference.
  always_comb begin
    oldest   = mem_q[wr_ptr_q];
    wr_ptr_d = wr_ptr_q;
    sum_d    = sum_q;
    fill_d   = fill_q;
    primed_d = primed_q;
    if (i_Data_Ready) begin
      sum_d    = sum_q + SumW'(i_Pulse_Count) - SumW'(oldest);
      wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
      if (fill_q != FillW'(Depth)) begin
        fill_d = fill_q + FillW'(1);
      end
      if (fill_q == FillW'(Depth - 1)) begin
        primed_d = 1'b1;
      end
    end
  end

  // Stage 2 and output handshake: a load always wins; overwriting an unaccepted result is sticky.
  always_comb begin
    accept    = (state_q == StFull) && speed_if.i_Speed_Ready;
    state_d   = state_q;
    speed_d   = speed_q;
    overrun_d = overrun_q;
    if (pend_q) begin
      speed_d = sum_q[SumW-1:AVG_LOG2];
      state_d = StFull;
      if ((state_q == StFull) && !speed_if.i_Speed_Ready) begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      sum_q     <= '0;
      fill_q    <= '0;
      pend_q    <= 1'b0;
      primed_q  <= 1'b0;
      speed_q   <= '0;
      state_q   <= StEmpty;
      overrun_q <= 1'b0;
    end else begin
      if (i_Data_Ready) begin
        mem_q[wr_ptr_q] <= i_Pulse_Count;
      end
      wr_ptr_q  <= wr_ptr_d;
      sum_q     <= sum_d;
      fill_q    <= fill_d;
      pend_q    <= i_Data_Ready;
      primed_q  <= primed_d;
      speed_q   <= speed_d;
      state_q   <= state_d;
      overrun_q <= overrun_d;
    end
  end

`ifdef ENC_FILTER_STALL_DETECT_EN
  logic [7:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (i_Data_Ready) begin
      if (i_Pulse_Count != '0) begin
        stall_cnt_d = '0;
      end else if (stall_cnt_q != 8'(STALL_WINDOWS)) begin
        stall_cnt_d = stall_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_Stalled = (stall_cnt_q == 8'(STALL_WINDOWS));
`else
  assign o_Stalled = 1'b0;
`endif

  assign speed_if.o_Speed       = speed_q;
  assign speed_if.o_Speed_Valid = (state_q == StFull);
  assign o_Primed               = primed_q;
  assign o_Overrun              = overrun_q;

endmodule

// File: tb/tb_encoder_speed_filter.sv
// Directed bench: stimulus pushes expected accepted speeds into a queue, a monitor pops on accept.
// Flag and timing checks are made inline at known cycles.
module tb_encoder_speed_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] count;
  logic        dr;
  logic        primed, overrun, stalled;

  encoder_speed_filter_if #(.COUNT_WIDTH(16)) spd_if ();

  encoder_speed_filter #(
    .COUNT_WIDTH  (16),
    .AVG_LOG2     (3),
    .STALL_WINDOWS(4)
  ) dut (
    .i_Clk        (clk),
    .i_Reset      (rst),
    .i_Pulse_Count(count),
    .i_Data_Ready (dr),
    .speed_if     (spd_if.master),
    .o_Primed     (primed),
    .o_Overrun    (overrun),
    .o_Stalled    (stalled)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passed = 0;
  logic [15:0] exp_q [$];

`ifdef ENC_FILTER_STALL_DETECT_EN
  localparam logic StallOn = 1'b1;
`else
  localparam logic StallOn = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard monitor: every accepted result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && spd_if.o_Speed_Valid && spd_if.i_Speed_Ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", {16'h0, spd_if.o_Speed}, 32'hDEAD_0000);
      end else begin
        check("accepted_speed", {16'h0, spd_if.o_Speed}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] v);
    count = v;
    dr    = 1'b1;
    tick();
    dr    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  int exp1 [8] = '{12, 25, 37, 50, 62, 75, 87, 100};
  logic [15:0] expf [9] = '{16'h1FFF, 16'h3FFF, 16'h5FFF, 16'h7FFF, 16'h9FFF,
                            16'hBFFF, 16'hDFFF, 16'hFFFF, 16'hDFFF};
  logic [15:0] ffff = 16'hFFFF;

  initial begin
    rst   = 1'b1;
    dr    = 1'b0;
    count = '0;
    spd_if.i_Speed_Ready = 1'b1;
    tick();
    do_reset();
    check("rst_speed",   {16'h0, spd_if.o_Speed}, 32'h0);
    check("rst_valid",   {31'h0, spd_if.o_Speed_Valid}, 32'h0);
    check("rst_primed",  {31'h0, primed}, 32'h0);
    check("rst_overrun", {31'h0, overrun}, 32'h0);
    check("rst_stalled", {31'h0, stalled}, 32'h0);

    // Ramp-up with 2-cycle latency and priming on the 8th sample.
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(16'(exp1[i]));
      strobe(16'd100);
      check("lat_n1_valid_low", {31'h0, spd_if.o_Speed_Valid}, 32'h0);
      check("primed", {31'h0, primed}, (i == 7) ? 32'h1 : 32'h0);
      tick();
      check("lat_n2_valid_high", {31'h0, spd_if.o_Speed_Valid}, 32'h1);
      check("lat_n2_speed", {16'h0, spd_if.o_Speed}, exp1[i]);
      repeat (8) tick();
    end
    check("no_overrun_ramp", {31'h0, overrun}, 32'h0);

    // Overwrite of an unconsumed result.
    do_reset();
    spd_if.i_Speed_Ready = 1'b0;
    strobe(16'd40);
    tick();
    check("ovr_speed1", {16'h0, spd_if.o_Speed}, 32'h5);
    check("ovr_valid1", {31'h0, spd_if.o_Speed_Valid}, 32'h1);
    check("ovr_flag0",  {31'h0, overrun}, 32'h0);
    exp_q.push_back(16'h000F);
    strobe(16'd80);
    check("ovr_stable", {16'h0, spd_if.o_Speed}, 32'h5);
    tick();
    check("ovr_speed2", {16'h0, spd_if.o_Speed}, 32'hF);
    check("ovr_valid2", {31'h0, spd_if.o_Speed_Valid}, 32'h1);
    check("ovr_flag1",  {31'h0, overrun}, 32'h1);
    spd_if.i_Speed_Ready = 1'b1;
    tick();
    check("ovr_valid_fall", {31'h0, spd_if.o_Speed_Valid}, 32'h0);
    check("ovr_sticky",     {31'h0, overrun}, 32'h1);

    // Full-scale counts must not wrap the sum.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      exp_q.push_back(expf[i]);
      strobe((i == 8) ? 16'h0000 : ffff);
      tick();
      check("full_speed", {16'h0, spd_if.o_Speed}, {16'h0, expf[i]});
      tick();
    end

    // Back-to-back strobes give back-to-back results.
    do_reset();
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd3);
    exp_q.push_back(16'd6);
    strobe(16'd8);
    strobe(16'd16);
    check("b2b_first", {16'h0, spd_if.o_Speed}, 32'd1);
    strobe(16'd24);
    check("b2b_second", {16'h0, spd_if.o_Speed}, 32'd3);
    tick();
    check("b2b_third", {16'h0, spd_if.o_Speed}, 32'd6);
    check("b2b_valid", {31'h0, spd_if.o_Speed_Valid}, 32'h1);
    tick();
    check("b2b_drained", {31'h0, spd_if.o_Speed_Valid}, 32'h0);

    // Stall detection on consecutive zero windows.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(16'd0);
      strobe(16'd0);
      check("stall_level", {31'h0, stalled}, (i == 3) ? {31'h0, StallOn} : 32'h0);
      tick();
    end
    exp_q.push_back(16'd0);
    strobe(16'd1);
    check("stall_clear", {31'h0, stalled}, 32'h0);
    repeat (2) tick();

    // Reset while holding an unaccepted result; strobe during reset is ignored.
    do_reset();
    spd_if.i_Speed_Ready = 1'b0;
    strobe(16'd200);
    tick();
    check("pre_rst_valid", {31'h0, spd_if.o_Speed_Valid}, 32'h1);
    check("pre_rst_speed", {16'h0, spd_if.o_Speed}, 32'd25);
    rst   = 1'b1;
    dr    = 1'b1;
    count = 16'd999;
    tick();
    dr    = 1'b0;
    rst   = 1'b0;
    check("mid_rst_speed",   {16'h0, spd_if.o_Speed}, 32'h0);
    check("mid_rst_valid",   {31'h0, spd_if.o_Speed_Valid}, 32'h0);
    check("mid_rst_primed",  {31'h0, primed}, 32'h0);
    check("mid_rst_overrun", {31'h0, overrun}, 32'h0);
    spd_if.i_Speed_Ready = 1'b1;
    repeat (3) tick();
    check("post_rst_quiet", {31'h0, spd_if.o_Speed_Valid}, 32'h0);
    exp_q.push_back(16'd8);
    strobe(16'd64);
    tick();
    check("post_rst_speed", {16'h0, spd_if.o_Speed}, 32'd8);
    repeat (4) tick();

    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/encoder_speed_filter.md
# encoder_speed_filter

Downstream consumer of the shaft-encoder pulse-count stage. Each `i_Data_Ready` strobe delivers one per-window pulse count. The block keeps a ring buffer of the last 2^AVG_LOG2 counts and maintains a running sum. It presents the moving-average speed over a valid/ready handshake to the telemetry/packetizer stage. It also flags buffer priming and result overruns, and optionally flags a stalled shaft.

## Interface
- `COUNT_WIDTH`, 16: width of incoming pulse count and outgoing speed.
- `AVG_LOG2`, 3: log2 of averaging depth; depth = 2^AVG_LOG2 (range 1..6).
- `STALL_WINDOWS`, 4: consecutive zero-count windows that declare a stall (range 1..255).

Ports:
- `i_Clk` in 1: system clock (50 MHz).
- `i_Reset` in 1: synchronous, active-high reset.
- `i_Pulse_Count` in COUNT_WIDTH: pulse count for the last window; sampled only on a strobe.
- `i_Data_Ready` in 1: one-cycle strobe marking `i_Pulse_Count` valid.
- `o_Speed` out COUNT_WIDTH: averaged count, floor(sum / 2^AVG_LOG2).
- `o_Speed_Valid` out 1: `o_Speed` holds an unconsumed result.
- `i_Speed_Ready` in 1: downstream accepts when high together with `o_Speed_Valid`.
- `o_Primed` out 1: at least 2^AVG_LOG2 samples received since reset.
- `o_Overrun` out 1: sticky; set when an unconsumed result is overwritten.
- `o_Stalled` out 1: stall flag (see Configuration).

## Operation
- Reset clears all ring-buffer entries, write pointer, sum, fill counter and every output to 0. A strobe in the reset cycle is ignored.
- Stage 1, on a strobe cycle:
  - Read the oldest entry at the write pointer.
  - Write the new count to that entry.
  - Update sum as sum + new − oldest.
  - Advance the write pointer modulo 2^AVG_LOG2.
  - Increment the fill counter, saturating at 2^AVG_LOG2.
  - Set an internal result-pending flag.
- Sum width is COUNT_WIDTH+AVG_LOG2 and can never overflow. The pointer wraps silently.
- Before priming, unwritten entries read as 0, so the average ramps up from 0. `o_Primed` rises in the same cycle that stage 1 absorbs the 2^AVG_LOG2-th sample and stays high until reset.
- Stage 2, the cycle after a stage-1 update:
  - Load `o_Speed` with sum[COUNT_WIDTH+AVG_LOG2−1 : AVG_LOG2] (truncating, no rounding).
  - Set `o_Speed_Valid`.
- Output handshake states are EMPTY and FULL.
  - EMPTY→FULL: on stage-2 load.
  - FULL→EMPTY: on `o_Speed_Valid` && `i_Speed_Ready` with no simultaneous load.
  - FULL with load and no accept: the new value overwrites `o_Speed`, valid stays high, and `o_Overrun` is set.
  - FULL with load and accept in the same cycle: the old value is consumed, the new value is loaded, valid stays high, and no overrun is recorded.
- `o_Speed` is stable while valid is high and not accepted.
- Strobes may arrive on consecutive cycles. Each strobe is absorbed with no loss; outputs follow the rules above.

## Timing
- Strobe at cycle N → sum updated at N+1 → `o_Speed` and `o_Speed_Valid` updated at N+2. Latency is 2 cycles; throughput is 1 sample per cycle.
- The accept takes effect at the clock edge where valid and ready are both high. Valid falls the next cycle unless a load coincides.
- `o_Overrun` is set at the edge of the overwriting load and holds until `i_Reset`.
- Reset mid-operation (pending stage-2 or FULL) discards everything within 1 cycle. No result is emitted afterwards until a new strobe arrives.

## Configuration
- `ENC_FILTER_STALL_DETECT_EN` defined:
  - A counter of consecutive zero-count samples, saturating at STALL_WINDOWS, updates in stage 1.
  - `o_Stalled` is high while the counter equals STALL_WINDOWS.
  - A nonzero sample clears the counter, and `o_Stalled` falls at that same stage-1 edge.
  - Reset clears the counter and `o_Stalled`.
- Not defined: counter logic is absent and `o_Stalled` is tied to 0. The port remains present.

## Test plan
- Reset, `i_Speed_Ready`=1, 8 strobes of count 100 spaced 10 cycles → `o_Speed` sequence 12,25,37,50,62,75,87,100. `o_Primed` rises with the 8th sample. Each valid appears 2 cycles after its strobe.
- `i_Speed_Ready`=0, strobes of 40 then 80 → `o_Speed`=0x0005 then 0x000F with valid high throughout and `o_Overrun`=1. Then ready=1 for one cycle → valid falls; `o_Overrun` stays 1.
- 8 strobes of 0xFFFF → sum 0x7FFF8 and `o_Speed`=0xFFFF with no wrap. A 9th strobe of 0 → `o_Speed`=0xDFFF.
- 3 strobes on consecutive cycles (values 8,16,24) with ready=1 → three results on consecutive cycles: 1,3,6.
- With macro: 4 strobes of 0 → `o_Stalled`=1 at the 4th stage-1 edge; a strobe of 1 → `o_Stalled`=0. Without macro → `o_Stalled` is always 0.
- Valid high and unaccepted, assert `i_Reset` for one cycle → all outputs 0 and ring buffer cleared. The next strobe of 64 → `o_Speed`=8.
